// File: rtl/sample_table_loader_if.sv
// Purpose: groups the load stream, status and read-port signals of sample_table_loader.
// Latency: none, wiring only.
// Backpressure: wr_ready (driven by the loader) qualifies every wr_valid beat.
//
// master: the side that streams words in and reads the table back.
// slave : the loader itself.
interface sample_table_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    // load side
    logic                  start;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  busy;
    logic                  loaded;
    // read side, same shape as the fixed sample ROM
    logic [ADDR_WIDTH-1:0] address;
    logic                  en;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;

    modport master (
        output start, wr_data, wr_valid, address, en,
        input  wr_ready, wr_count, busy, loaded, data, data_valid
    );

    modport slave (
        input  start, wr_data, wr_valid, address, en,
        output wr_ready, wr_count, busy, loaded, data, data_valid
    );
endinterface

// File: rtl/sample_table_loader.sv
// Purpose: run-time loadable 64-entry sample table, drop-in for the fixed sine ROM read port.
// Latency: read data registered one cycle after en; a load takes 64 accepted beats after LOAD entry.
// Backpressure: wr_ready is high for the whole LOAD state, so beats are accepted one per cycle.
//
// Ports: clk, rst_n (async active-low) plus bus (slave modport):
//   start/wr_data/wr_valid/wr_ready  word stream that fills the table from address 0
//   wr_count/busy/loaded             load progress and status
//   address/en/data/data_valid       ROM-compatible read port, read-first on collision
module sample_table_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sample_table_loader_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   wr_count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  data_valid_q;
    logic                  beat;
    logic                  last_beat;
    logic                  load_entry;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // next-state logic; load_entry marks the edge that moves us into LOAD
    always_comb begin
        state_d    = state_q;
        load_entry = 1'b0;
        beat       = (state_q == LOAD) && bus.wr_valid;
        last_beat  = beat && (wr_ptr_q == {ADDR_WIDTH{1'b1}});
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = LOAD;
                    load_entry = 1'b1;
                end
            end
            LOAD: begin
                // start is deliberately not looked at here: no restart mid-load
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pointer and count are cleared on the edge into LOAD so the first LOAD
    // cycle already writes address 0 and reports a count of 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
        end else if (load_entry) begin
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
        end else if (beat) begin
            wr_ptr_q   <= wr_ptr_q + ADDR_WIDTH'(1);
            wr_count_q <= wr_count_q + (ADDR_WIDTH + 1)'(1);
        end
    end

    // table storage is not reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    // registered read; a same-cycle write to the same address lands after
    // this sample, so the old word is returned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= bus.en;
            if (bus.en) begin
                data_q <= mem[bus.address];
            end
        end
    end

    assign bus.wr_ready   = (state_q == LOAD);
    assign bus.busy       = (state_q == LOAD);
    assign bus.loaded     = (state_q == DONE);
    assign bus.wr_count   = wr_count_q;
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
endmodule

// File: doc/sample_table_loader.md
Name: sample_table_loader

Overview:
- Writer-side counterpart to the sine-wave sample ROM.
- Holds a 64 x 32-bit sample table in on-chip dual-port RAM.
- Write side loads the table from a valid/ready word stream after a start pulse.
- Read side matches the ROM: address plus enable, one-cycle latency. The existing tick-driven pointer generator can therefore read it unchanged, and a table loaded at run time replaces the fixed ROM contents.

Parameters:
- DATA_WIDTH, 32, width of each table word.
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH (64) entries, derived, not overridable.

Ports:
- clk  in  1  system clock (100 MHz); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a table load.
- wr_data  in  DATA_WIDTH  word to write.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  loader accepts a word this cycle.
- wr_count  out  ADDR_WIDTH+1  words written in the current/last load, 0..64.
- busy  out  1  high while in LOAD.
- loaded  out  1  high once all DEPTH words are written; held until the next start.
- address  in  ADDR_WIDTH  read address.
- en  in  1  read enable.
- data  out  DATA_WIDTH  read data, registered.
- data_valid  out  1  en delayed by one cycle.

Behaviour:
- Reset values (async assert, sync release): FSM=IDLE, wr_ptr=0, wr_count=0, wr_ready=0, busy=0, loaded=0, data=0, data_valid=0. RAM contents are not reset.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start -> LOAD.
  - LOAD: wr_ptr and wr_count are cleared on entry.
  - LOAD: accepting the beat at wr_ptr=DEPTH-1 -> DONE.
  - DONE: start -> LOAD.
- wr_ready=1 exactly in LOAD. It is combinational from state, so it is high in the first LOAD cycle, the cycle after start.
- A beat occurs when wr_valid && wr_ready:
  - mem[wr_ptr] <= wr_data;
  - wr_ptr increments, wrapping 63->0;
  - wr_count increments.
- wr_valid is ignored outside LOAD; no write occurs.
- Back-to-back beats are supported, one per cycle. A full load takes 64 cycles minimum after the LOAD entry cycle.
- loaded rises in the cycle after the last beat, together with the DONE entry; busy falls in the same cycle.
- start in LOAD is ignored: no restart, pointer unchanged.
- start in DONE: loaded and wr_count clear in the next cycle as LOAD is re-entered.
- Reset mid-load aborts the load: loaded=0, and a new start is required. Partially written RAM words remain but are undefined to the user.
- Read port:
  - Active in every state; reads are not gated by loaded.
  - If en at edge N: data <= mem[address], visible after edge N, with data_valid=1 for that one cycle.
  - If !en: data holds its previous value and data_valid=0.
- Same-address read and write in the same cycle: read-first, i.e. data returns the old word.
- Widths: wr_count is ADDR_WIDTH+1 bits so 64 is representable; wr_ptr is ADDR_WIDTH bits and wraps naturally.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, release, wr_valid=1 with no start -> wr_ready=0, busy=0, loaded=0, wr_count=0; data=0 and data_valid=0 throughout.
- Full load: start pulse, then 64 back-to-back beats wr_data=0xA5000000+i -> busy for 64 cycles; loaded=1 the cycle after beat 63; wr_count=64; wr_ready=0 afterwards.
- Throttled load plus ignored start: wr_valid toggled 1/0, start pulsed mid-load -> wr_count advances only on valid cycles; start has no effect; loaded after 64 accepted beats.
- Readback with tick reader: en pulsed every 1000 cycles, address counting 0..63 and wrapping -> data=0xA5000000+address one cycle after each en; data_valid is a single-cycle pulse; data holds between ticks.
- Collision: in a second load, write 0x12345678 to address 5 while en=1, address=5 in the same cycle -> data=0xA5000005 (old word); the next read of address 5 returns 0x12345678.
- Reset mid-load: assert rst_n low after 20 beats -> all outputs at reset values immediately; after release, start plus 64 beats -> loaded=1, wr_count=64.
